// File: rtl/conv_load_sched_if.sv
// Stream-in / result-out handshake bundle for conv_load_sched.
// Ports (slave = scheduler side):
//   s_data, s_valid -> in   sample stream and its valid
//   s_ready         <- out  sample accepted when s_valid & s_ready
//   m_valid, m_idx  <- out  result index offered to the consumer
//   m_ready         -> in   consumer accepts the offered result
interface conv_load_sched_if #(
    parameter int WIDTH   = 16,
    parameter int LOGSIZE = 6
);
    logic [WIDTH-1:0]   s_data;
    logic               s_valid;
    logic               s_ready;
    logic               m_valid;
    logic               m_ready;
    logic [LOGSIZE-1:0] m_idx;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_valid,
        input  m_idx,
        output m_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_valid,
        output m_idx,
        input  m_ready
    );
endinterface

// File: rtl/conv_load_sched.sv
// Load/strobe/output sequencer for the convolution datapath's F and X
// shift memories (F: WIDTH x FSIZE, X: WIDTH x SIZE).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   bus        slave modport: s_data/s_valid/s_ready in, m_valid/m_idx/m_ready out
//   mem_data   out  data_in for both memories (s_data passed through)
//   f_wr_en    out  F memory write enable
//   x_wr_en    out  X memory write enable
//   snap_f     out  F memory data_out holds the full F vector this cycle
//   snap_x     out  X memory data_out holds the full X vector this cycle
//   busy       out  anything other than idle LOAD_F with nothing loaded
//   proto_err  out  sticky flag: stream bubble seen mid-vector
module conv_load_sched #(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 64,
    parameter int FSIZE   = 8,
    parameter int LOGSIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_load_sched_if.slave     bus,
    output logic [WIDTH-1:0]     mem_data,
    output logic                 f_wr_en,
    output logic                 x_wr_en,
    output logic                 snap_f,
    output logic                 snap_x,
    output logic                 busy,
    output logic                 proto_err
);

    localparam logic [2:0] LOAD_F = 3'd0;
    localparam logic [2:0] WAIT_F = 3'd1;
    localparam logic [2:0] LOAD_X = 3'd2;
    localparam logic [2:0] WAIT_X = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;

    localparam logic [LOGSIZE-1:0] F_LAST   = LOGSIZE'(FSIZE - 1);
    localparam logic [LOGSIZE-1:0] X_LAST   = LOGSIZE'(SIZE - 1);
    localparam logic [LOGSIZE-1:0] IDX_LAST = LOGSIZE'(SIZE - FSIZE);
    localparam logic [LOGSIZE-1:0] ONE      = LOGSIZE'(1);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [LOGSIZE-1:0] cnt;
    logic [LOGSIZE-1:0] cnt_nx;
    logic [LOGSIZE-1:0] idx;
    logic [LOGSIZE-1:0] idx_nx;
    logic               err_nx;

    logic in_load_f;
    logic in_load_x;
    logic loading;
    logic accept;
    logic bubble;
    logic last;
    logic m_fire;

    assign in_load_f = (state == LOAD_F);
    assign in_load_x = (state == LOAD_X);
    assign loading   = in_load_f | in_load_x;
    assign accept    = loading & bus.s_valid;

    // A gap after the first sample of a vector breaks the gap-free burst
    // the shift memory relies on; idling before the first sample is fine.
    assign bubble = loading & ~bus.s_valid & (cnt != '0);

    assign last   = in_load_f ? (cnt == F_LAST) : (cnt == X_LAST);
    assign m_fire = (state == OUT) & bus.m_ready;

    assign mem_data    = bus.s_data;
    assign bus.s_ready = loading;
    assign f_wr_en     = bus.s_valid & in_load_f;
    assign x_wr_en     = bus.s_valid & in_load_x;

    // The wait states reuse cnt as a two-cycle timer: the memory needs one
    // edge to take the last write and one more to register data_out.
    assign snap_f = (state == WAIT_F) & (cnt != '0);
    assign snap_x = (state == WAIT_X) & (cnt != '0);

    assign bus.m_valid = (state == OUT);
    assign bus.m_idx   = idx;
    assign busy        = ~in_load_f | (cnt != '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        err_nx   = proto_err | bubble;
        case (state)
            LOAD_F, LOAD_X: begin
                if (accept) begin
                    if (last) begin
                        state_nx = in_load_f ? WAIT_F : WAIT_X;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end else if (bubble) begin
                    // Restart the vector; stale entries shift out.
                    cnt_nx = '0;
                end
            end
            WAIT_F, WAIT_X: begin
                if (cnt == '0) begin
                    cnt_nx = ONE;
                end else begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = (state == WAIT_F) ? LOAD_X : OUT;
                end
            end
            OUT: begin
                if (m_fire) begin
                    if (idx == IDX_LAST) begin
                        state_nx = LOAD_F;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + ONE;
                    end
                end
            end
            default: begin
                state_nx = LOAD_F;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LOAD_F;
            cnt       <= '0;
            idx       <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            proto_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_conv_load_sched.sv
// Randomized scoreboard bench for conv_load_sched (SIZE=8, FSIZE=3).
// The driver plans each run from the protocol timeline and queues expectations.
module tb_conv_load_sched;

    localparam int W    = 16;
    localparam int SZ   = 8;
    localparam int FS   = 3;
    localparam int LS   = 3;
    localparam int NOUT = SZ - FS + 1;

    logic          clk;
    logic          reset;
    logic [W-1:0]  mem_data;
    logic          f_wr_en;
    logic          x_wr_en;
    logic          snap_f;
    logic          snap_x;
    logic          busy;
    logic          proto_err;

    conv_load_sched_if #(.WIDTH(W), .LOGSIZE(LS)) bus ();

    conv_load_sched #(
        .WIDTH(W), .SIZE(SZ), .FSIZE(FS), .LOGSIZE(LS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .mem_data(mem_data),
        .f_wr_en(f_wr_en),
        .x_wr_en(x_wr_en),
        .snap_f(snap_f),
        .snap_x(snap_x),
        .busy(busy),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    bit chk_en;
    bit e_ready, e_fwr, e_xwr, e_busy, e_mvalid, e_err;
    int sf_q[$];
    int sx_q[$];
    logic [LS-1:0] idx_q[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        else
            passed++;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            bit es;
            chk("s_ready", bus.s_ready, e_ready);
            chk("f_wr_en", f_wr_en, e_fwr);
            chk("x_wr_en", x_wr_en, e_xwr);
            chk("busy", busy, e_busy);
            chk("m_valid", bus.m_valid, e_mvalid);
            chk("proto_err", proto_err, e_err);
            chk("mem_data", mem_data, bus.s_data);
            es = (sf_q.size() != 0) && (sf_q[0] == cyc);
            if (es) void'(sf_q.pop_front());
            chk("snap_f", snap_f, es);
            es = (sx_q.size() != 0) && (sx_q[0] == cyc);
            if (es) void'(sx_q.pop_front());
            chk("snap_x", snap_x, es);
            if (bus.m_valid) begin
                if (idx_q.size() == 0) begin
                    chk("m_valid_unexpected", bus.m_valid, 0);
                end else begin
                    chk("m_idx", bus.m_idx, idx_q[0]);
                    if (bus.m_ready) void'(idx_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit rdy, input bit fw, input bit xw,
                           input bit bsy, input bit mv);
        e_ready  = rdy;
        e_fwr    = fw;
        e_xwr    = xw;
        e_busy   = bsy;
        e_mvalid = mv;
    endtask

    task automatic drive_vec(input bit is_f, input int len, input bit bub,
                             output int last_cyc);
        int bub_at;
        int i;
        bub_at = bub ? int'($urandom_range(len - 1, 1)) : -1;
        repeat ($urandom_range(2, 0)) begin
            bus.s_valid = 1'b0;
            bus.s_data  = W'($urandom);
            bus.m_ready = 1'($urandom_range(1, 0));
            set_exp(1, 0, 0, !is_f, 0);
            step();
        end
        i = 0;
        last_cyc = 0;
        while (i < len) begin
            bus.s_data  = W'($urandom);
            bus.m_ready = 1'($urandom_range(1, 0));
            if (i == bub_at) begin
                bus.s_valid = 1'b0;
                set_exp(1, 0, 0, 1, 0);
                step();
                e_err  = 1'b1;
                bub_at = -1;
                i      = 0;
            end else begin
                bus.s_valid = 1'b1;
                set_exp(1, is_f, !is_f, !is_f || i != 0, 0);
                last_cyc = cyc;
                step();
                i++;
            end
        end
    endtask

    task automatic wait2(input bit is_f, input int last_cyc);
        if (is_f) sf_q.push_back(last_cyc + 2);
        else      sx_q.push_back(last_cyc + 2);
        repeat (2) begin
            bus.s_valid = 1'($urandom_range(1, 0));
            bus.s_data  = W'($urandom);
            bus.m_ready = 1'($urandom_range(1, 0));
            set_exp(0, 0, 0, 1, 0);
            step();
        end
    endtask

    task automatic do_out(input int rst_at, input bit bp);
        int acc;
        int hold;
        bit r;
        for (int k = 0; k < NOUT; k++) idx_q.push_back(LS'(k));
        acc  = 0;
        hold = 0;
        while (acc < NOUT) begin
            bus.s_valid = 1'($urandom_range(1, 0));
            bus.s_data  = W'($urandom);
            set_exp(0, 0, 0, 1, 1);
            if (acc == rst_at) begin
                bus.m_ready = 1'b0;
                reset = 1'b0;
                step();
                reset = 1'b1;
                e_err = 1'b0;
                idx_q.delete();
                return;
            end
            r = ($urandom_range(3, 0) != 0);
            if (bp && acc == 2 && hold < 3) begin
                r = 1'b0;
                hold++;
            end
            bus.m_ready = r;
            step();
            if (r) acc++;
        end
    endtask

    task automatic run(input bit bf, input bit bx, input int rst_at, input bit bp);
        int l;
        drive_vec(1, FS, bf, l);
        wait2(1, l);
        drive_vec(0, SZ, bx, l);
        wait2(0, l);
        do_out(rst_at, bp);
    endtask

    initial begin
        chk_en      = 1'b0;
        e_err       = 1'b0;
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        repeat (2) step();
        reset  = 1'b1;
        chk_en = 1'b1;

        run(0, 0, -1, 0);
        run(0, 0, -1, 1);
        run(1, 0, -1, 0);
        run(0, 1, -1, 0);
        run(0, 0, 3, 0);
        run(0, 0, -1, 0);
        repeat (8)
            run($urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                -1, 1'($urandom_range(1, 0)));

        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        repeat (3) step();
        chk_en = 1'b0;
        chk("idx_q_drained", idx_q.size(), 0);
        chk("snap_f_q_drained", sf_q.size(), 0);
        chk("snap_x_q_drained", sx_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
